if_fetch: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a request/grant/response handshake. Fetched instructions are buffered in a 2-entry queue and presented to IF/ID, which holds when `hazard` is high. On a branch or jump resolved in ID, the block redirects the PC, drops wrong-path instructions and asserts the IF/ID flush.

---
 rtl/if_fetch.sv | 133 +++++++++++++
 tb/tb_if_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, one-outstanding imem request FSM, 2-entry fetch queue
`timescale 1ns/1ps

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        redirectInput,
    input  logic [31:0] redirectTargetInput,
    output logic        imemReqOutput,
    output logic [31:0] imemAddrOutput,
    input  logic        imemReadyInput,
    input  logic        imemRespValidInput,
    input  logic [31:0] imemRespDataInput,
    output logic [31:0] pcOutput,
    output logic [31:0] instructionOutput,
    output logic        ifFlushOutput
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];
    logic        head_q, head_d;
    logic [1:0]  occ_q, occ_d;

    logic        active;
    logic        redir;
    logic        not_empty;
    logic        consume;
    logic        busy;
    logic        room;
    logic        resp_take;
    logic        grant;
    logic        push;
    logic        wr_idx;
    logic        unused_target_bits;

    assign unused_target_bits = ^redirectTargetInput[1:0];

    // Everything visible is gated by reset so the reset cycle presents a clean bubble.
    assign active    = ~reset;
    assign redir     = active & redirectInput & ~hazard;
    assign not_empty = (occ_q != 2'd0);
    assign consume   = not_empty & ~hazard & ~redir;
    assign busy      = (state_q != IDLE);
    assign room      = ({1'b0, occ_q} + {2'b00, busy}) < (3'd2 + {2'b00, consume});
    assign resp_take = (state_q == PENDING) & imemRespValidInput;
    assign grant     = imemReqOutput & imemReadyInput;
    assign push      = active & resp_take & ~redir;
    assign wr_idx    = head_q ^ occ_q[0];

    assign imemReqOutput     = active & ~redir & room & ((state_q == IDLE) | resp_take);
    assign imemAddrOutput    = pc_q;
    assign ifFlushOutput     = redir;
    assign pcOutput          = (active & not_empty) ? fifo_pc_q[head_q] + 32'd4 : 32'd0;
    assign instructionOutput = (active & not_empty) ? fifo_instr_q[head_q] : 32'd0;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        head_d       = head_q;
        occ_d        = occ_q;

        if (redir) begin
            pc_d = {redirectTargetInput[31:2], 2'b00};
        end else if (grant) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end

        unique case (state_q)
            IDLE: begin
                if (grant) state_d = PENDING;
            end
            PENDING: begin
                if (imemRespValidInput) state_d = grant ? PENDING : IDLE;
                else if (redir)         state_d = DISCARD;
            end
            DISCARD: begin
                if (imemRespValidInput) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_pc_d[wr_idx]    = req_pc_q;
            fifo_instr_d[wr_idx] = imemRespDataInput;
        end

        if (redir) begin
            occ_d = 2'd0;
        end else begin
            occ_d = occ_q + {1'b0, push} - {1'b0, consume};
            if (consume) head_d = ~head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'd0;
            fifo_pc_q    <= '{default: 32'd0};
            fifo_instr_q <= '{default: 32'd0};
            head_q       <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            head_q       <= head_d;
            occ_q        <= occ_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed bench for if_fetch with in-order memory model and presentation scoreboard
`timescale 1ns/1ps

module tb_if_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        hazard;
    logic        redirectInput;
    logic [31:0] redirectTargetInput;
    logic        imemReqOutput;
    logic [31:0] imemAddrOutput;
    logic        imemReadyInput;
    logic        imemRespValidInput;
    logic [31:0] imemRespDataInput;
    logic [31:0] pcOutput;
    logic [31:0] instructionOutput;
    logic        ifFlushOutput;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk                 (clk),
        .reset               (reset),
        .hazard              (hazard),
        .redirectInput       (redirectInput),
        .redirectTargetInput (redirectTargetInput),
        .imemReqOutput       (imemReqOutput),
        .imemAddrOutput      (imemAddrOutput),
        .imemReadyInput      (imemReadyInput),
        .imemRespValidInput  (imemRespValidInput),
        .imemRespDataInput   (imemRespDataInput),
        .pcOutput            (pcOutput),
        .instructionOutput   (instructionOutput),
        .ifFlushOutput       (ifFlushOutput)
    );

    typedef struct {
        logic [31:0] pcp4;
        logic [31:0] instr;
        int          id;
        int          avail;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        int          due;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          next_id  = 0;
    logic [31:0] mpc;
    logic        mon_g, mon_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory: in-order responses, each delivered `lat` cycles after its grant; instr = ~addr.
    initial begin
        imemRespValidInput = 1'b0;
        imemRespDataInput  = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imemRespValidInput = 1'b1;
                imemRespDataInput  = ~mem_q[0].addr;
                foreach (exp_q[i])
                    if (exp_q[i].id == mem_q[0].id) exp_q[i].avail = cyc + 1;
                void'(mem_q.pop_front());
            end else begin
                imemRespValidInput = 1'b0;
                imemRespDataInput  = 32'hDEAD_BEEF;
            end
        end
    end

    // Per-cycle monitor, sampled 1ns before the rising edge.
    initial begin
        mpc = RPC;
        forever begin
            @(negedge clk);
            #4;
            mon_g  = imemReqOutput & imemReadyInput;
            mon_rd = redirectInput & ~hazard;
            if (reset) begin
                check("reset_req",   32'(imemReqOutput), 32'd0);
                check("reset_pc",    pcOutput, 32'd0);
                check("reset_instr", instructionOutput, 32'd0);
                check("reset_flush", 32'(ifFlushOutput), 32'd0);
                exp_q.delete();
                mpc = RPC;
            end else begin
                check("flush", 32'(ifFlushOutput), 32'(mon_rd));
                if (imemReqOutput) check("req_addr", imemAddrOutput, mpc);
                if (exp_q.size() > 0 && exp_q[0].avail >= 0 && exp_q[0].avail <= cyc) begin
                    check("pres_pc",    pcOutput, exp_q[0].pcp4);
                    check("pres_instr", instructionOutput, exp_q[0].instr);
                    if (!hazard && !mon_rd) void'(exp_q.pop_front());
                end else begin
                    check("bubble_pc",    pcOutput, 32'd0);
                    check("bubble_instr", instructionOutput, 32'd0);
                end
                if (mon_rd) begin
                    exp_q.delete();
                    mpc = {redirectTargetInput[31:2], 2'b00};
                end else if (mon_g) begin
                    check("one_outstanding", 32'(mem_q.size()), 32'd0);
                    exp_q.push_back('{pcp4: mpc + 32'd4, instr: ~mpc, id: next_id, avail: -1});
                    mem_q.push_back('{id: next_id, addr: mpc, due: cyc + lat});
                    next_id++;
                    mpc = mpc + 32'd4;
                end
            end
            cyc++;
        end
    end

    initial begin
        logic [31:0] p0, i0, a0;
        int          ng;
        bit          found;

        reset               = 1'b1;
        hazard              = 1'b0;
        redirectInput       = 1'b0;
        redirectTargetInput = 32'd0;
        imemReadyInput      = 1'b1;
        tick(); tick();

        // Reset release and streaming
        tick(); reset = 1'b0; #4;
        check("first_req", 32'(imemReqOutput), 32'd1);
        check("first_addr", imemAddrOutput, RPC);
        ng = 0;
        for (int k = 0; k < 8; k++) begin
            tick(); #4;
            if (imemReqOutput && imemReadyInput) ng++;
        end
        check("stream_rate", 32'(ng), 32'd8);

        // Stall for 3 cycles
        tick(); hazard = 1'b1; #4;
        p0 = pcOutput; i0 = instructionOutput;
        check("stall_presented", 32'(p0 != 32'd0), 32'd1);
        tick(); #4;
        tick(); #4;
        check("stall_pc",    pcOutput, p0);
        check("stall_instr", instructionOutput, i0);
        check("stall_noreq", 32'(imemReqOutput), 32'd0);
        tick(); hazard = 1'b0; #4;
        repeat (4) begin tick(); #4; end

        // Redirect while a 3-cycle request is pending
        tick(); lat = 3; #4;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #4;
            if (imemReqOutput && imemReadyInput) found = 1'b1;
        end
        check("grant_wait_a", 32'(found), 32'd1);
        tick(); redirectInput = 1'b1; redirectTargetInput = 32'h0000_2002; #4;
        check("redir_flush", 32'(ifFlushOutput), 32'd1);
        tick(); redirectInput = 1'b0; lat = 1; #4;
        check("flush_pulse", 32'(ifFlushOutput), 32'd0);
        check("discard_noreq", 32'(imemReqOutput), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #4;
            if (imemReqOutput) found = 1'b1;
        end
        check("redir_req_seen", 32'(found), 32'd1);
        check("redir_addr", imemAddrOutput, 32'h0000_2000);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #4;
            if (pcOutput != 32'd0) found = 1'b1;
        end
        check("redir_pres_seen", 32'(found), 32'd1);
        check("redir_first_pc", pcOutput, 32'h0000_2004);

        // Redirect raised during a stall is held off
        tick(); hazard = 1'b1; #4;
        tick(); #4;
        tick(); #4;
        a0 = imemAddrOutput;
        tick(); redirectInput = 1'b1; redirectTargetInput = 32'h0000_3000; #4;
        check("stall_redir_flush", 32'(ifFlushOutput), 32'd0);
        check("stall_redir_pc", imemAddrOutput, a0);
        tick(); #4;
        check("stall_redir_pc2", imemAddrOutput, a0);
        tick(); hazard = 1'b0; #4;
        check("late_redir_flush", 32'(ifFlushOutput), 32'd1);
        tick(); redirectInput = 1'b0; #4;
        check("late_redir_addr", imemAddrOutput, 32'h0000_3000);
        check("late_redir_req", 32'(imemReqOutput), 32'd1);
        repeat (3) begin tick(); #4; end

        // Grant backpressure for 4 cycles
        tick(); imemReadyInput = 1'b0; #4;
        a0 = imemAddrOutput;
        for (int k = 0; k < 3; k++) begin
            tick(); #4;
            check("bp_addr_hold", imemAddrOutput, a0);
        end
        check("bp_bubble_pc", pcOutput, 32'd0);
        check("bp_bubble_instr", instructionOutput, 32'd0);
        tick(); imemReadyInput = 1'b1; #4;
        check("bp_resume_req", 32'(imemReqOutput), 32'd1);
        check("bp_resume_addr", imemAddrOutput, a0);
        repeat (3) begin tick(); #4; end

        // Wrap-around
        tick(); redirectInput = 1'b1; redirectTargetInput = 32'hFFFF_FFFC; #4;
        tick(); redirectInput = 1'b0; #4;
        check("wrap_addr0", imemAddrOutput, 32'hFFFF_FFFC);
        tick(); #4;
        check("wrap_addr1", imemAddrOutput, 32'h0000_0000);
        repeat (3) begin tick(); #4; end

        // Reset while a request is in flight
        tick(); lat = 3; #4;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #4;
            if (imemReqOutput && imemReadyInput) found = 1'b1;
        end
        check("grant_wait_b", 32'(found), 32'd1);
        tick(); reset = 1'b1; #4;
        tick(); #4;
        tick(); #4;
        tick(); reset = 1'b0; lat = 1; #4;
        check("rst_restart_req", 32'(imemReqOutput), 32'd1);
        check("rst_restart_addr", imemAddrOutput, RPC);
        repeat (8) begin tick(); #4; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
